// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the PS SPI master and the PL register-file responder.
//   spi_sclk    : SPI clock, driven by the master
//   spi_cs_n    : chip select, active low, driven by the master
//   spi_mosi    : master-out/slave-in data
//   spi_miso    : slave-out/master-in data
//   spi_miso_oe : MISO output enable from the slave
interface spi_slave_regfile_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a byte-wide register file and burst auto-increment.
// SCLK/CS_N/MOSI are oversampled on axi_aclk (which must be >= 8x SCLK).
// Protocol: first byte {rnw, a[6:0]}, then data bytes written to / read from
// consecutive registers starting at a[ADDR_W-1:0], wrapping modulo 2**ADDR_W.
// Ports:
//   axi_aclk    : system clock
//   axi_areset  : asynchronous active-high reset
//   spi         : SPI pin bundle (slave modport)
//   wr_stb      : one-cycle pulse per register written over SPI
//   wr_addr     : address of the last write, valid with wr_stb
//   wr_data     : data of the last write, valid with wr_stb
//   regs_flat   : all registers, reg[i] = regs_flat[8i+7:8i]
module spi_slave_regfile #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    spi_slave_regfile_if.slave          spi,
    output logic                        wr_stb,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [7:0]                  wr_data,
    output logic [8*(2**ADDR_W)-1:0]    regs_flat
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWr,
        StRd
    } state_e;

    state_e state_q, state_d;

    // Synchronizers. cs_n resets low on purpose: together with armed_q this makes
    // a transaction already in flight at reset release invisible until cs_n has
    // been seen high at least once.
    logic [1:0] sclk_sync_q;
    logic       sclk_hist_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       armed_q, armed_d;

    logic       sclk_s, cs_n_s, mosi_s;
    logic       sclk_rise, sclk_fall;

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        regs_q [NumRegs];

    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic              reg_we;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sclk_sync_q <= 2'b00;
            sclk_hist_q <= 1'b0;
            cs_sync_q   <= 2'b00;
            mosi_sync_q <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi.spi_sclk};
            sclk_hist_q <= sclk_sync_q[1];
            cs_sync_q   <= {cs_sync_q[0], spi.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
            armed_q     <= armed_d;
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign cs_n_s    = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign armed_d   = armed_q | cs_n_s;

    // Byte assembled from the seven already-shifted bits and the bit on this rise.
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign cmd_addr  = rx_byte[ADDR_W-1:0];
    assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

    // FSM: state register.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A deasserted cs_n wins over everything.
    always_comb begin
        state_d = state_q;
        if (cs_n_s) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (armed_q) state_d = StCmd;
                StCmd:  if (byte_done) state_d = rx_byte[7] ? StRd : StWr;
                StWr:   state_d = StWr;
                StRd:   state_d = StRd;
            endcase
        end
    end

    // FSM: datapath controls and next values.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        addr_d    = addr_q;
        reg_we    = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (state_q == StIdle || cs_n_s) begin
            // Partial bytes are dropped and the shifters cleared between transactions.
            bit_cnt_d = 3'd0;
            rx_sr_d   = 7'd0;
            tx_sr_d   = 8'd0;
        end else begin
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_sr_d   = rx_byte[6:0];
            end
            unique case (state_q)
                StIdle: ;
                StCmd: begin
                    if (byte_done) begin
                        if (rx_byte[7]) begin
                            tx_sr_d = regs_q[cmd_addr];
                            addr_d  = cmd_addr + ADDR_W'(1);
                        end else begin
                            addr_d  = cmd_addr;
                        end
                    end
                end
                StWr: begin
                    if (byte_done) begin
                        reg_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_byte;
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end
                StRd: begin
                    if (byte_done) begin
                        tx_sr_d = regs_q[addr_q];
                        addr_d  = addr_q + ADDR_W'(1);
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        // The fall right after a reload must not shift, or bit 7 is lost.
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 7'd0;
            tx_sr_q   <= 8'd0;
            addr_q    <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            addr_q    <= addr_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (reg_we) begin
            regs_q[addr_q] <= rx_byte;
        end
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end

    assign spi.spi_miso    = tx_sr_q[7];
    assign spi.spi_miso_oe = armed_q & ~cs_n_s;
    assign wr_stb          = wr_stb_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- PL-side SPI responder (mode 0, CPOL=0/CPHA=0) serving the PS SPI master driven from Linux spidev.
- Oversamples SCLK/CS_N/MOSI on axi_aclk and decodes a byte-oriented command protocol.
- Holds a byte-wide register file that the PS can write and read back in bursts with auto-increment.
- Exports register contents and per-write strobes to fabric logic.

Parameters:
- ADDR_W, 4, register address width; file holds 2**ADDR_W 8-bit registers.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- axi_aclk  in  1  system clock; must be at least 8x the SCLK frequency.
- axi_areset  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock from the PS master; asynchronous to axi_aclk.
- spi_cs_n  in  1  chip select, active low; asynchronous.
- spi_mosi  in  1  master-out data; asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; high while cs_n is synchronized low.
- wr_stb  out  1  one-cycle pulse per register written by SPI.
- wr_addr  out  ADDR_W  address of the write; valid with wr_stb.
- wr_data  out  8  data of the write; valid with wr_stb.
- regs_flat  out  8*2**ADDR_W  all registers; reg[i] = regs_flat[8i+7:8i].

Behaviour:
- Reset values: all registers = RESET_VAL; spi_miso=0; spi_miso_oe=0; wr_stb=0; wr_addr=0; wr_data=0; state=IDLE.
- Synchronization: sclk, cs_n and mosi each pass through a 2-flop synchronizer, plus one history flop for edge detection.
  - Rise = sync 0->1; fall = sync 1->0.
  - Edge-detect latency is 3 cycles from the pin.
  - MOSI is sampled from its synchronized copy on the detected rise.
- States:
  - IDLE: cs_n high.
  - CMD: first byte.
  - WR: write data bytes.
  - RD: read data bytes.
  - IDLE->CMD on synced cs_n low; bit_cnt=0 and shift_reg cleared.
- bit_cnt: 3-bit, increments on each sclk rise while cs_n is low; byte completes when it wraps 7->0.
- CMD byte: {rnw, a[6:0]}, MSB first.
  - addr <= a[ADDR_W-1:0]; upper address bits are ignored.
  - rnw=0 -> WR; rnw=1 -> RD.
- WR: on each completed byte:
  - reg[addr] <= byte; wr_stb=1 for exactly one cycle (cycle after the 8th rise is detected), with wr_addr=addr and wr_data=byte.
  - Then addr <= addr+1, wrapping modulo 2**ADDR_W.
- RD:
  - On the cycle the CMD byte (or each RD byte) completes, tx_sr <= reg[addr], then addr <= addr+1 (wraps).
  - spi_miso = tx_sr[7] continuously.
  - On an sclk fall with bit_cnt != 0, tx_sr shifts left, filling 0.
  - A fall with bit_cnt == 0 (the fall after the 8th rise) does not shift.
  - Bytes received on MOSI in RD are ignored.
  - Read data reflects register contents at load time; a fabric-visible write in the same cycle is not possible, since SPI is the only writer.
- MISO during CMD and WR: 0. spi_miso_oe = ~cs_n_sync.
- Timing budget: MISO updates 3-4 aclk after an SCLK fall, which is within half an SCLK period at the 8x minimum ratio.
- cs_n deassert (synced rise), any state:
  - Go to IDLE immediately; a partial byte is discarded (no write, no wr_stb).
  - tx_sr cleared; spi_miso=0, spi_miso_oe=0.
  - A new cs_n assertion starts a fresh CMD; address does not carry across transactions.
- SCLK edges while cs_n is high are ignored.
- Reset mid-transaction: all state and registers return to reset values immediately (async). After release, logic waits for cs_n high before accepting a new CMD, so a transaction already in progress is ignored until cs_n deasserts.
- cs_n low with zero SCLK edges, then high: no effect.

Test Plan:
- Reset with RESET_VAL=00, ADDR_W=4 -> regs_flat all 0, miso_oe=0, wr_stb=0.
- Burst write: cs_n low, send 0x03, 0xA5, 0x5A at aclk/8, cs_n high -> reg3=A5, reg4=5A; exactly two wr_stb pulses carrying (3,A5) then (4,5A).
- Burst read after the above: send 0x83 then two dummy bytes -> MISO returns A5 then 5A MSB-first, stable at every SCLK rise; MISO=0 during the command byte; miso_oe high throughout cs_n low.
- Wrap and upper-bit masking: write cmd 0x7F (addr -> 0xF), data 11, 22 -> reg15=11, reg0=22.
- Abort: cs_n high after 5 bits of a WR data byte -> no wr_stb, register unchanged; next transaction 0x81 reads reg1 correctly.
- Reset asserted mid-RD burst -> miso=0, oe=0, regs=RESET_VAL; transaction resumes correctly only after cs_n toggles high then low.
